// File: rtl/tx_frame_buffer_if.sv
// Handshake and status bundle between the frame producer/consumer side and tx_frame_buffer.
// The master modport is the environment side; the slave modport is the buffer itself.
interface tx_frame_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 9
);
    logic                      i_start;
    logic [DEPTH*DATA_W-1:0]   i_mat;
    logic                      i_ready;
    logic [DATA_W-1:0]         o_data;
    logic                      o_valid;
    logic                      o_busy;
    logic                      o_done;

    modport master (
        output i_start, i_mat, i_ready,
        input  o_data, o_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_mat, i_ready,
        output o_data, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/tx_frame_buffer.sv
// Snapshots DEPTH words on a start request and streams [header] body [xor checksum]
// over a valid/ready handshake, with busy and one-cycle done status.
module tx_frame_buffer #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 9,
    parameter bit                HEADER_EN = 1'b1,
    parameter logic [DATA_W-1:0] HEADER    = DATA_W'(8'hA5),
    parameter bit                CSUM_EN   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    tx_frame_buffer_if.slave     bus
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        CSUM = 2'd3
    } state_t;

    state_t                    state_r;
    logic [IDX_W-1:0]          idx_r;
    logic [DEPTH*DATA_W-1:0]   snap_r;
    logic [DATA_W-1:0]         csum_r;
    logic [DATA_W-1:0]         data_r;
    logic                      valid_r;
    logic                      busy_r;
    logic                      done_r;

    logic                      xfer_s;
    logic [IDX_W-1:0]          idx_inc_s;
    logic [DATA_W-1:0]         next_word_s;
    logic [DATA_W-1:0]         csum_next_s;

    function automatic logic [DATA_W-1:0] csum_fold(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] word
    );
        return acc ^ word;
    endfunction

    // Handshake decode and look-ahead of the word that follows the current one.
    always_comb begin
        xfer_s      = valid_r & bus.i_ready;
        idx_inc_s   = idx_r + 1'b1;
        next_word_s = snap_r[idx_inc_s*DATA_W +: DATA_W];
        csum_next_s = csum_fold(csum_r, data_r);
    end

    // Frame sequencer; o_data is preloaded so each word appears the cycle after its predecessor is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            snap_r  <= '0;
            csum_r  <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.i_start) begin
                        snap_r  <= bus.i_mat;
                        csum_r  <= '0;
                        idx_r   <= '0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        if (HEADER_EN) begin
                            state_r <= HDR;
                            data_r  <= HEADER;
                        end else begin
                            state_r <= BODY;
                            data_r  <= bus.i_mat[DATA_W-1:0];
                        end
                    end else begin
                        data_r  <= '0;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                HDR: begin
                    if (xfer_s) begin
                        state_r <= BODY;
                        data_r  <= snap_r[DATA_W-1:0];
                    end
                end
                BODY: begin
                    if (xfer_s) begin
                        csum_r <= csum_next_s;
                        if (idx_r == LAST_IDX) begin
                            if (CSUM_EN) begin
                                state_r <= CSUM;
                                data_r  <= csum_next_s;
                            end else begin
                                state_r <= IDLE;
                                data_r  <= '0;
                                valid_r <= 1'b0;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            idx_r  <= idx_inc_s;
                            data_r <= next_word_s;
                        end
                    end
                end
                CSUM: begin
                    if (xfer_s) begin
                        state_r <= IDLE;
                        data_r  <= '0;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    data_r  <= '0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data  = data_r;
    assign bus.o_valid = valid_r;
    assign bus.o_busy  = busy_r;
    assign bus.o_done  = done_r;
endmodule

// File: tb/tb_tx_frame_buffer.sv
// Directed bench: default 9-word framed buffer plus a 16-bit single-word unframed instance.
module tb_tx_frame_buffer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tx_frame_buffer_if #(.DATA_W(8),  .DEPTH(9)) a_if ();
    tx_frame_buffer_if #(.DATA_W(16), .DEPTH(1)) b_if ();

    tx_frame_buffer #(
        .DATA_W(8), .DEPTH(9), .HEADER_EN(1'b1), .HEADER(8'hA5), .CSUM_EN(1'b1)
    ) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (a_if)
    );

    tx_frame_buffer #(
        .DATA_W(16), .DEPTH(1), .HEADER_EN(1'b0), .HEADER(16'h00A5), .CSUM_EN(1'b0)
    ) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b_if)
    );

    // header, words 1..9, xor of 1..9
    logic [7:0] exp_a [11] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                               8'h06, 8'h07, 8'h08, 8'h09, 8'h01};
    logic [71:0] mat_a = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready high, 1: ready toggling, 2: 3-cycle stalls, 3: mid-frame i_mat change + stray start
    task automatic consume_a(input int mode);
        int         got = 0;
        int         cyc = 0;
        logic [7:0] prev = 8'h00;
        bit         prev_stall = 1'b0;
        bit         rdy;
        while (got < 11 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            a_if.i_start = 1'b0;
            check_eq("valid_in_frame", 32'(a_if.o_valid), 32'd1);
            check_eq("busy_in_frame", 32'(a_if.o_busy), 32'd1);
            if (prev_stall) check_eq("stall_hold", 32'(a_if.o_data), 32'(prev));
            case (mode)
                1:       rdy = ((cyc % 2) == 1);
                2:       rdy = ((cyc % 5) >= 3);
                3: begin
                    rdy = 1'b1;
                    if (cyc == 2) a_if.i_mat = {9{8'hFF}};
                    if (cyc == 5) a_if.i_start = 1'b1;
                end
                default: rdy = 1'b1;
            endcase
            a_if.i_ready = rdy;
            if (rdy) begin
                check_eq("word", 32'(a_if.o_data), 32'(exp_a[got]));
                got++;
            end
            prev_stall = !rdy;
            prev       = a_if.o_data;
        end
        check_eq("frame_words", 32'(got), 32'd11);
        if (mode == 0) check_eq("frame_cycles", 32'(cyc), 32'd11);
        @(negedge clk);
        a_if.i_start = 1'b0;
        check_eq("done_pulse", 32'(a_if.o_done), 32'd1);
        check_eq("done_busy", 32'(a_if.o_busy), 32'd0);
        check_eq("done_valid", 32'(a_if.o_valid), 32'd0);
        check_eq("done_data", 32'(a_if.o_data), 32'd0);
        @(negedge clk);
        check_eq("done_once", 32'(a_if.o_done), 32'd0);
        check_eq("idle_after", 32'(a_if.o_busy), 32'd0);
        a_if.i_mat = mat_a;
    endtask

    initial begin
        rst          = 1'b1;
        a_if.i_start = 1'b0;
        a_if.i_ready = 1'b0;
        a_if.i_mat   = mat_a;
        b_if.i_start = 1'b0;
        b_if.i_ready = 1'b0;
        b_if.i_mat   = 16'hBEEF;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(a_if.o_valid), 32'd0);
        check_eq("rst_busy", 32'(a_if.o_busy), 32'd0);
        check_eq("rst_done", 32'(a_if.o_done), 32'd0);
        check_eq("rst_data", 32'(a_if.o_data), 32'd0);
        check_eq("rst_b_valid", 32'(b_if.o_valid), 32'd0);
        rst = 1'b0;

        // ready without start must not create a frame
        a_if.i_ready = 1'b1;
        b_if.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_valid", 32'(a_if.o_valid), 32'd0);
            check_eq("idle_data", 32'(a_if.o_data), 32'd0);
            check_eq("idle_busy", 32'(a_if.o_busy), 32'd0);
        end

        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            a_if.i_start = 1'b1;
            consume_a(m);
        end

        // reset at the 4th transfer, then a fresh full frame
        @(negedge clk);
        a_if.i_start = 1'b1;
        a_if.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_if.i_start = 1'b0;
            check_eq("pre_rst_word", 32'(a_if.o_data), 32'(exp_a[k]));
            if (k == 3) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_valid", 32'(a_if.o_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(a_if.o_busy), 32'd0);
        check_eq("mid_rst_done", 32'(a_if.o_done), 32'd0);
        @(negedge clk);
        check_eq("mid_rst_no_done", 32'(a_if.o_done), 32'd0);
        check_eq("mid_rst_idle", 32'(a_if.o_valid), 32'd0);
        a_if.i_start = 1'b1;
        consume_a(0);

        // single-word frame, back-to-back start in the done cycle
        @(negedge clk);
        b_if.i_start = 1'b1;
        @(negedge clk);
        b_if.i_start = 1'b0;
        check_eq("b_valid1", 32'(b_if.o_valid), 32'd1);
        check_eq("b_data1", 32'(b_if.o_data), 32'h0000BEEF);
        check_eq("b_busy1", 32'(b_if.o_busy), 32'd1);
        check_eq("b_nodone1", 32'(b_if.o_done), 32'd0);
        @(negedge clk);
        check_eq("b_done1", 32'(b_if.o_done), 32'd1);
        check_eq("b_valid_gap", 32'(b_if.o_valid), 32'd0);
        check_eq("b_data_gap", 32'(b_if.o_data), 32'd0);
        b_if.i_start = 1'b1;
        @(negedge clk);
        b_if.i_start = 1'b0;
        check_eq("b_valid2", 32'(b_if.o_valid), 32'd1);
        check_eq("b_data2", 32'(b_if.o_data), 32'h0000BEEF);
        @(negedge clk);
        check_eq("b_done2", 32'(b_if.o_done), 32'd1);
        check_eq("b_busy2", 32'(b_if.o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tx_frame_buffer.md
# tx_frame_buffer

Parametrised frame serializer sitting between the matrix producer and the UART transmitter. On a start request it snapshots a flat array of `DEPTH` words, then streams an optional header word, the words in index order, and an optional XOR checksum word over a valid/ready handshake. It replaces the fixed 9-byte buffer with configurable width/depth, input capture, framing, and explicit busy/done status.

## Interface
- `DATA_W`, 8, word width in bits (≥1)
- `DEPTH`, 9, body words per frame (≥1)
- `HEADER_EN`, 1, 1 = emit `HEADER` word before body
- `HEADER`, 8'hA5, header value (`DATA_W` bits)
- `CSUM_EN`, 1, 1 = emit XOR checksum after body

- `i_clk`  in  1  single clock, all logic on rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_start`  in  1  request a frame; honoured only in IDLE
- `i_mat`  in  DEPTH*DATA_W  body words; word k = `i_mat[k*DATA_W +: DATA_W]`
- `i_ready`  in  1  consumer accepts `o_data` this cycle when `o_valid` is high
- `o_data`  out  DATA_W  current word; 0 whenever `o_valid` = 0
- `o_valid`  out  1  `o_data` holds a frame word
- `o_busy`  out  1  frame in progress (not IDLE)
- `o_done`  out  1  one-cycle pulse after final word accepted

## Operation
- States: IDLE, HDR, BODY, CSUM. Reset → IDLE; all outputs 0, index 0, snapshot and checksum registers 0.
- IDLE: `i_start`=1 → copy `i_mat` into snapshot register, clear checksum, index ← 0; next state HDR if `HEADER_EN`, else BODY.
- Transfer = cycle where `o_valid` & `i_ready`; state/index advance only on a transfer.
- HDR: `o_data` = `HEADER`; on transfer → BODY.
- BODY: `o_data` = snapshot[index]; on transfer checksum ^= word; if index = DEPTH-1 → CSUM if `CSUM_EN`, else IDLE; otherwise index + 1.
- CSUM: `o_data` = checksum (XOR of all DEPTH body words; header excluded); on transfer → IDLE.
- Frame end transition to IDLE sets `o_done`=1 for exactly the following cycle.
- Index width `max(1,$clog2(DEPTH))`; index never exceeds DEPTH-1, no wrap.
- Boundaries:
  - `i_start` outside IDLE: ignored, no re-capture.
  - `i_mat` changes mid-frame: no effect (snapshot used).
  - `i_ready` while `o_valid`=0: ignored.
  - `o_valid` high with `i_ready` low: `o_data` and state held indefinitely.
  - `i_rst` mid-frame: IDLE next cycle, `o_valid`/`o_busy`/`o_done` 0, no done pulse; `i_rst` overrides `i_start`.
  - DEPTH=1, HEADER_EN=0, CSUM_EN=0: single-word frame.

## Timing
- `i_start` sampled at edge t in IDLE → `o_busy`, `o_valid` high from cycle t+1 with first word.
- `o_valid` = `o_busy` (registered state decode); no bubbles within a frame: `i_ready` held high gives one word per cycle.
- Frame length L = HEADER_EN + DEPTH + CSUM_EN words; with `i_ready` constantly high, last transfer in cycle t+L, `o_done` in cycle t+L+1 with `o_busy`=0.
- `i_start` in the `o_done` cycle is accepted (IDLE); next frame valid the cycle after.
- `o_data` changes only on the edge following a transfer or frame start.

## Test plan
- Defaults, `i_mat` words 0x01..0x09, `i_ready`=1, start pulse → A5,01,02,03,04,05,06,07,08,09,01 (XOR) on 11 consecutive cycles, `o_done` pulse next cycle.
- Same frame, `i_ready` toggled 1/0 each cycle and random 3-cycle stalls → identical sequence, `o_data` stable during stalls, no duplicates/drops.
- Start, then change `i_mat` to all 0xFF and pulse `i_start` during BODY → original words/checksum emitted, no restart.
- `i_rst` asserted at 4th transfer → next cycle `o_valid`=`o_busy`=`o_done`=0; fresh start gives full frame from header.
- DATA_W=16, DEPTH=1, HEADER_EN=0, CSUM_EN=0, word 0xBEEF → single transfer 0xBEEF, `o_done` next cycle; back-to-back start in done cycle yields second 0xBEEF two cycles later.
- `i_ready` high in IDLE with no start → `o_valid` stays 0, `o_data`=0, state unchanged.
